// File: rtl/booth_multiplier_radix4.sv
// Sequential Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned, start/busy/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 recoding (2 bits/cycle); otherwise radix-2 (1 bit/cycle).
module booth_multiplier_radix4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);
  localparam int E  = WIDTH + 1;
  localparam int AW = WIDTH + 3;
  localparam int PW = 2 * WIDTH;
`ifdef BOOTH_RADIX4_EN
  localparam int QW = E + (E % 2);
  localparam int K  = QW / 2;
`else
  localparam int QW = E;
  localparam int K  = E;
`endif
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   m_q, a_q, a_sum, a_d;
  logic [QW-1:0]   q_q, q_d, q_ext;
  logic            qm1_q, qm1_d;
  logic [E-1:0]    m_ext, q_x;
  logic [CW-1:0]   cnt_q;

  always_comb begin
    m_ext = {is_signed & multiplicand[WIDTH-1], multiplicand};
    q_x   = {is_signed & multiplier[WIDTH-1], multiplier};
    // The extended multiplier is already a correct signed value; pad to QW with its sign.
    q_ext = {QW{q_x[E-1]}};
    q_ext[E-1:0] = q_x;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: a_sum = a_q + m_q;
      3'b011:         a_sum = a_q + (m_q << 1);
      3'b100:         a_sum = a_q - (m_q << 1);
      3'b101, 3'b110: a_sum = a_q - m_q;
      default:        a_sum = a_q;
    endcase
    a_d   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    q_d   = {a_sum[1:0], q_q[QW-1:2]};
    qm1_d = q_q[1];
`else
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    a_d   = {a_sum[AW-1], a_sum[AW-1:1]};
    q_d   = {a_sum[0], q_q[QW-1:1]};
    qm1_d = q_q[0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_q     <= {{2{m_ext[E-1]}}, m_ext};
            a_q     <= '0;
            q_q     <= q_ext;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(K - 1)) begin
            product <= PW'({a_d, q_d});
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
